// File: rtl/rgb_luminance_pipe_if.sv
// Pixel handshake bundle for the RGB-to-luminance front end.
// The source drives the in_* side and accepts the out_* side; the pipe is the slave.
interface rgb_luminance_pipe_if #(
    parameter int unsigned W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_r;
    logic [7:0]   in_g;
    logic [7:0]   in_b;
    logic         in_sof;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_l;
    logic [W-1:0] out_r;
    logic [W-1:0] out_g;
    logic [W-1:0] out_b;
    logic         out_sof;
    logic         out_clamp;
    logic [15:0]  clamp_cnt;

    modport master (
        output in_valid, in_r, in_g, in_b, in_sof, out_ready,
        input  in_ready, out_valid, out_l, out_r, out_g, out_b,
               out_sof, out_clamp, clamp_cnt
    );

    modport slave (
        input  in_valid, in_r, in_g, in_b, in_sof, out_ready,
        output in_ready, out_valid, out_l, out_r, out_g, out_b,
               out_sof, out_clamp, clamp_cnt
    );
endinterface

// File: rtl/rgb_luminance_pipe.sv
// Three-stage RGB to luminance pipe feeding tone reproduction: weighted luma sum,
// rounding plus Q8 channel scaling, then gain with saturation and a per-frame clamp count.
module rgb_luminance_pipe #(
    parameter int unsigned W      = 32,
    parameter int unsigned KR     = 77,
    parameter int unsigned KG     = 150,
    parameter int unsigned KB     = 29,
    parameter int unsigned GAIN   = 1625,
    parameter int unsigned LCLAMP = 162550
) (
    input logic                clk,
    input logic                reset,
    rgb_luminance_pipe_if.slave bus
);

    logic         adv;
    logic         accept;
    logic         out_hs;

    logic         v1;
    logic [16:0]  sum1;
    logic [7:0]   r1;
    logic [7:0]   g1;
    logic [7:0]   b1;
    logic         sof1;

    logic         v2;
    logic [7:0]   y2;
    logic [W-1:0] r2;
    logic [W-1:0] g2;
    logic [W-1:0] b2;
    logic         sof2;

    logic         v3;
    logic [W-1:0] l3;
    logic [W-1:0] r3;
    logic [W-1:0] g3;
    logic [W-1:0] b3;
    logic         sof3;
    logic         clamp3;
    logic [15:0]  cnt;

    logic [16:0]  sum_c;
    logic [7:0]   y_c;
    logic [W+7:0] p_c;
    logic         clamp_c;
    logic [W-1:0] l_c;

    // Global stall: the whole pipe moves only when the output slot can drain.
    assign adv    = !v3 || bus.out_ready;
    assign accept = bus.in_valid && adv;
    assign out_hs = v3 && bus.out_ready;

    assign sum_c = 17'(KR) * 17'(bus.in_r)
                 + 17'(KG) * 17'(bus.in_g)
                 + 17'(KB) * 17'(bus.in_b);

    assign y_c = 8'((18'(sum1) + 18'd128) >> 8);

    // Full-width product so the saturation compare sees every bit.
    assign p_c     = (W+8)'(y2) * (W+8)'(GAIN);
    assign clamp_c = p_c > (W+8)'(LCLAMP);
    assign l_c     = clamp_c ? W'(LCLAMP) : p_c[W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            v1     <= 1'b0;
            sum1   <= '0;
            r1     <= '0;
            g1     <= '0;
            b1     <= '0;
            sof1   <= 1'b0;
            v2     <= 1'b0;
            y2     <= '0;
            r2     <= '0;
            g2     <= '0;
            b2     <= '0;
            sof2   <= 1'b0;
            v3     <= 1'b0;
            l3     <= '0;
            r3     <= '0;
            g3     <= '0;
            b3     <= '0;
            sof3   <= 1'b0;
            clamp3 <= 1'b0;
        end else if (adv) begin
            v1     <= accept;
            sum1   <= sum_c;
            r1     <= bus.in_r;
            g1     <= bus.in_g;
            b1     <= bus.in_b;
            sof1   <= bus.in_sof;

            v2     <= v1;
            y2     <= y_c;
            r2     <= W'({r1, 8'h00});
            g2     <= W'({g1, 8'h00});
            b2     <= W'({b1, 8'h00});
            sof2   <= sof1;

            v3     <= v2;
            l3     <= l_c;
            r3     <= r2;
            g3     <= g2;
            b3     <= b2;
            sof3   <= sof2;
            clamp3 <= clamp_c;
        end
    end

    // Counter restarts on the first pixel of each frame, counting that pixel if clamped.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (out_hs) begin
            if (sof3) begin
                cnt <= {15'd0, clamp3};
            end else if (clamp3 && (cnt != 16'hFFFF)) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = v3;
    assign bus.out_l     = l3;
    assign bus.out_r     = r3;
    assign bus.out_g     = g3;
    assign bus.out_b     = b3;
    assign bus.out_sof   = sof3;
    assign bus.out_clamp = clamp3;
    assign bus.clamp_cnt = cnt;

endmodule

// File: doc/rgb_luminance_pipe.md
Name: rgb_luminance_pipe

Overview:
- Pipelined front-end stage that feeds the tone-reproduction stage.
- Accepts 8-bit RGB pixels and produces four aligned fixed-point values: the luminance L and the Q8-scaled channels IN_R, IN_G and IN_B. All four sit in the same integer domain the tone-reproduction breakpoints use (L full scale 162550).
- Valid/ready handshake on both sides, 3-stage pipeline with global stall, saturation of L with a per-frame clamp counter.

Parameters:
- W, 32, width of all fixed-point outputs; matches size_int.
- KR, 77, red luma weight (Q8).
- KG, 150, green luma weight (Q8).
- KB, 29, blue luma weight (Q8).
- GAIN, 1625, luma-to-L gain (Q8, ≈6.3496×256).
- LCLAMP, 162550, maximum L output (Lmax).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  input pixel valid
- in_ready  out  1  stage can accept pixel
- in_r  in  8  red
- in_g  in  8  green
- in_b  in  8  blue
- in_sof  in  1  first pixel of frame
- out_valid  out  1  output valid
- out_ready  in  1  downstream accepts
- out_l  out  W  luminance L
- out_r  out  W  in_r×256
- out_g  out  W  in_g×256
- out_b  out  W  in_b×256
- out_sof  out  1  sof aligned with pixel
- out_clamp  out  1  L was saturated for this pixel
- clamp_cnt  out  16  clamped pixels in current frame

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high, and sampled on the rising edge of clk.
- Reset values: all stage valid bits are 0, all data registers are 0, and clamp_cnt is 0. out_valid=0, out_l/r/g/b=0, out_sof=0, out_clamp=0.
- Reset mid-operation: all in-flight pixels are discarded and none of them is emitted.
- Advance rule: adv = !out_valid || out_ready. in_ready = adv, combinationally. A pixel is accepted when in_valid && in_ready.
- Stall: when adv=1 all three stages shift one position. When adv=0 every register holds, and out_* stays stable while out_valid=1.
- S1 (valid v1):
  - sum = KR·r + KG·g + KB·b, 17 bits unsigned.
  - Register r, g, b and sof alongside it.
  - An empty slot is a bubble: v1 is loaded from (in_valid && in_ready).
- S2:
  - y = (sum + 128) >> 8, 8 bits. With the default weights the maximum is 255, so y does not overflow.
  - Also form the Q8 channels: r<<8, g<<8, b<<8, zero-extended to W.
- S3:
  - p = y × GAIN, computed at full width (8 + 32 bits, no truncation).
  - If p > LCLAMP: out_l = LCLAMP and out_clamp = 1. Otherwise out_l = p[W-1:0] and out_clamp = 0.
- Latency: exactly 3 clk from acceptance to out_valid when there are no stalls. Throughput is 1 pixel/clk. Bubbles propagate as out_valid=0.
- clamp_cnt:
  - Updated only on an output handshake (out_valid && out_ready).
  - If the handshaken pixel has out_sof: clamp_cnt = out_clamp ? 1 : 0.
  - Otherwise, if out_clamp: clamp_cnt increments and saturates at 65535.
  - No other event changes clamp_cnt.
- Ordering: pixel order is preserved. in_sof is carried unchanged to out_sof.
- Simultaneous events: an input accept and an output handshake in the same cycle are both legal and are required for full throughput. A stalled output with in_valid=1 gives in_ready=0, and no pixel is lost or duplicated.

Test Plan:
- Reset, then a single pixel r=128, g=90, b=78 with out_ready=1. Required: out_valid exactly 3 cycles after acceptance, out_l=162500, out_r=32768, out_g=23040, out_b=19968, out_clamp=0.
- Pixel 255/255/255 → y=255, p=414375, so out_l=162550 and out_clamp=1. Pixel 0/0/0 → out_l=0, out_r=out_g=out_b=0, out_clamp=0. Pixel 0/0/255 → out_l=47125, out_b=65280.
- Stream 8 pixels back-to-back, deassert out_ready for 4 cycles mid-stream, then reassert. Required: in_ready=0 during the stall, out_* held stable, all 8 pixels emitted in order with no loss or duplicates, and 1 pixel/clk outside the stall.
- Frame A: sof on pixel 0, 3 white pixels and 2 black → clamp_cnt=3 after the last handshake. Frame B: sof pixel is white → clamp_cnt=1 on that handshake.
- Assert reset while 3 pixels are in flight. Required: next cycle out_valid=0 and clamp_cnt=0. No stale pixel appears afterwards; a new pixel emerges after 3 cycles with correct values.
- Random in_valid/out_ready toggling, 1000 pixels. Required: outputs match a reference model bit-exactly and in order.
